// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one half-adder pair slice reused LSB-first under FSM control.
// Optional subtract mode (x - y) is enabled by defining SERIAL_ADDER_SUB_EN.

module halfAdder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] xs, ys, rsum;
    logic [CW-1:0]    cnt;
    logic             c, cout_r;
    logic             p, g1, s, g2, cnext;
    logic             sub_i;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_i = sub;
`else
    assign sub_i = 1'b0;
`endif

    halfAdder u_ha1 (.a(xs[0]), .b(ys[0]), .s(p), .c(g1));
    halfAdder u_ha2 (.a(p),     .b(c),     .s(s), .c(g2));

    assign cnext = g1 | g2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Subtract is x + ~y + 1: invert ys on load and force the carry-in.
    // The result register shifts in from the MSB, so the shift form also covers WIDTH=1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs     <= '0;
            ys     <= '0;
            rsum   <= '0;
            cnt    <= '0;
            c      <= 1'b0;
            cout_r <= 1'b0;
        end else if (state == S_IDLE && start) begin
            xs  <= x;
            ys  <= sub_i ? ~y : y;
            c   <= sub_i | cin;
            cnt <= '0;
        end else if (state == S_RUN) begin
            rsum <= (rsum >> 1) | (WIDTH'(s) << (WIDTH - 1));
            xs   <= xs >> 1;
            ys   <= ys >> 1;
            c    <= cnext;
            cnt  <= cnt + CW'(1);
            if (cnt == LAST) begin
                cout_r <= cnext;
            end
        end
    end

    assign sum  = rsum;
    assign cout = cout_r;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): vector table, corner sequences, random ops vs arithmetic model.
module tb_serial_adder_ctrl;
    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] x, y;
    logic         cin;
    logic         sub;
    logic         busy, done;
    logic [W-1:0] sum;
    logic         cout;

    int n_checks = 0;
    int n_fail   = 0;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural reference: plain (W+1)-bit arithmetic.
    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sb);
        if (sb)
            return {1'b0, a} - {1'b0, b} + (W+1)'(1 << W);
        else
            return {1'b0, a} + {1'b0, b} + (W+1)'(ci);
    endfunction

    task automatic apply_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                            input logic sb, input logic [W-1:0] es, input logic ec, input string tag);
        int run_ok;
        x = a; y = b; cin = ci; sub = sb; start = 1'b1;
        tick();
        start = 1'b0;
        run_ok = 0;
        for (int i = 0; i < W; i++) begin
            if (busy === 1'b1 && done === 1'b0) run_ok++;
            tick();
        end
        chk({tag, "_busy_cycles"}, run_ok, W);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        tick();
        chk({tag, "_done_one_cycle"}, done, 0);
        chk({tag, "_sum_hold"}, sum, es);
    endtask

    initial begin
        int ndone;
        int last_i;
        logic [W-1:0] cap_sum;
        logic [W:0]   r;
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        vecs[0] = '{8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[5] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};

        rst_n = 1'b0; start = 1'b0; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
        tick(); tick(); tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_sum", sum, 0);
        chk("reset_cout", cout, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 7; i++)
            apply_op(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0, vecs[i].esum, vecs[i].ecout, $sformatf("vec%0d", i));

        // start re-asserted during RUN must be ignored
        x = 8'h11; y = 8'h22; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        x = 8'hF0; y = 8'h0F; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        ndone = 0; cap_sum = '0;
        for (int i = 0; i < W + 6; i++) begin
            if (done === 1'b1) begin
                ndone++;
                cap_sum = sum;
            end
            tick();
        end
        chk("ignore_start_done_count", ndone, 1);
        chk("ignore_start_sum", cap_sum, 8'h33);
        chk("ignore_start_idle_busy", busy, 0);
        chk("ignore_start_sum_hold", sum, 8'h33);

        // reset in the middle of RUN aborts with cleared outputs
        apply_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "pre_abort");
        x = 8'h3C; y = 8'h42; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < W + 3; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        chk("abort_no_done", ndone, 0);
        apply_op(8'h3C, 8'h42, 1'b0, 1'b0, 8'h7E, 1'b0, "after_abort");

        // reset wins over start on the same edge
        x = 8'h01; y = 8'h01; start = 1'b1; rst_n = 1'b0;
        tick();
        chk("rst_over_start_busy", busy, 0);
        rst_n = 1'b1; start = 1'b0;
        tick();
        chk("rst_over_start_idle", busy, 0);

        // start held: one accept per W+2 cycles
        x = 8'h01; y = 8'h01; cin = 1'b0; start = 1'b1;
        ndone = 0; last_i = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (done === 1'b1) begin
                ndone++;
                chk("held_sum", sum, 8'h02);
                if (last_i >= 0) chk("held_period", i - last_i, W + 2);
                else chk("held_first_latency", i, W + 1);
                last_i = i;
            end
        end
        start = 1'b0;
        chk("held_done_count", ndone, 3);
        tick(); tick(); tick();

`ifdef SERIAL_ADDER_SUB_EN
        apply_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, "sub_borrow");
        apply_op(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1, "sub_noborrow");
`endif

        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADDER_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            r = ref_add(ra, rb, rc, rs);
            apply_op(ra, rb, rc, rs, r[W-1:0], r[W], $sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
